// File: rtl/game_phase_controller.sv
// Game phase sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER, with score and level tracking.
// Optional pause input in PLAY is compiled in when GAME_PAUSE_EN is defined.
//
//   state       | meaning
//   ------------+---------------------------------------------------
//   S_IDLE      | waiting for start, one-second timer stopped
//   S_COUNTDOWN | pre-game countdown, decremented on each sec_pulse
//   S_PLAY      | game running, score/level advance, spawner enabled
//   S_OVER      | ship hit, score/level frozen for display
module game_phase_controller #(
  parameter int COUNTDOWN_SEC = 3,
  parameter int LEVEL_SEC     = 10,
  parameter int MAX_LEVEL     = 7,
  parameter int LEVEL_W       = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               collision,
  input  logic               sec_pulse,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  output logic               timer_enable,
  output logic               spawn_enable,
  output logic [1:0]         phase,
  output logic [3:0]         countdown,
  output logic [LEVEL_W-1:0] level,
  output logic               level_up,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAY      = 2'd2,
    S_OVER      = 2'd3
  } state_t;

  localparam logic [3:0]         CD_INIT   = 4'(COUNTDOWN_SEC);
  localparam logic [7:0]         LVL_LAST  = 8'(LEVEL_SEC - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_LEVEL);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               state;
  state_t               state_nxt;
  logic                 timer_enable_nxt;
  logic                 spawn_enable_nxt;
  logic                 game_over_nxt;

  logic [7:0]           lvl_sec;
  logic [7:0]           lvl_sec_nxt;
  logic [3:0]           countdown_nxt;
  logic [LEVEL_W-1:0]   level_nxt;
  logic                 level_up_nxt;
  logic [SCORE_W-1:0]   score_nxt;

  logic                 paused;
  logic                 play_tick;
  logic                 cd_last;
  logic                 lvl_wrap;

`ifdef GAME_PAUSE_EN
  assign paused = (state == S_PLAY) && pause;
`else
  assign paused = 1'b0;
`endif

  // A collision in the same cycle as sec_pulse ends the game without scoring that second.
  assign play_tick = (state == S_PLAY) && sec_pulse && !collision && !paused;
  assign cd_last   = (countdown <= 4'd1);
  assign lvl_wrap  = (lvl_sec == LVL_LAST);

  assign phase = state;

  // State register, also holding the registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      timer_enable <= 1'b0;
      spawn_enable <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer_enable <= timer_enable_nxt;
      spawn_enable <= spawn_enable_nxt;
      game_over    <= game_over_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_COUNTDOWN;
      S_COUNTDOWN: if (sec_pulse && cd_last) state_nxt = S_PLAY;
      S_PLAY:      if (collision && !paused) state_nxt = S_OVER;
      S_OVER:      if (start) state_nxt = S_COUNTDOWN;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Pause only matters once already in PLAY, so the countdown->play edge always enables.
  always_comb begin
    timer_enable_nxt = (state_nxt == S_COUNTDOWN) || ((state_nxt == S_PLAY) && !paused);
    spawn_enable_nxt = (state_nxt == S_PLAY) && !paused;
    game_over_nxt    = (state_nxt == S_OVER);
  end

  always_comb begin
    countdown_nxt = countdown;
    score_nxt     = score;
    level_nxt     = level;
    lvl_sec_nxt   = lvl_sec;
    level_up_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) countdown_nxt = CD_INIT;
      end
      S_COUNTDOWN: begin
        if (sec_pulse) countdown_nxt = cd_last ? 4'd0 : (countdown - 4'd1);
      end
      S_PLAY: begin
        if (play_tick) begin
          if (score != SCORE_MAX) score_nxt = score + 1'b1;
          if (lvl_wrap) begin
            lvl_sec_nxt = 8'd0;
            if (level < LVL_MAX) begin
              level_nxt    = level + 1'b1;
              level_up_nxt = 1'b1;
            end
          end else begin
            lvl_sec_nxt = lvl_sec + 8'd1;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          countdown_nxt = CD_INIT;
          score_nxt     = '0;
          level_nxt     = '0;
          lvl_sec_nxt   = 8'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      countdown <= 4'd0;
      score     <= '0;
      level     <= '0;
      lvl_sec   <= 8'd0;
      level_up  <= 1'b0;
    end else begin
      countdown <= countdown_nxt;
      score     <= score_nxt;
      level     <= level_nxt;
      lvl_sec   <= lvl_sec_nxt;
      level_up  <= level_up_nxt;
    end
  end

endmodule

// File: tb/tb_game_phase_controller.sv
// Directed bench for game_phase_controller: expectations queued per step, checked after each clock.
// A second instance with SCORE_W=4 shares the stimulus to cover score saturation.
module tb_game_phase_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       sec_pulse = 1'b0;
  logic       pause = 1'b0;

  logic       timer_enable, spawn_enable, level_up, game_over;
  logic [1:0] phase;
  logic [3:0] countdown;
  logic [2:0] level;
  logic [7:0] score;

  logic       timer_enable2, spawn_enable2, level_up2, game_over2;
  logic [1:0] phase2;
  logic [3:0] countdown2;
  logic [2:0] level2;
  logic [3:0] score2;

  always #5 clk = ~clk;

  game_phase_controller dut (
    .clk(clk), .rst(rst), .start(start), .collision(collision), .sec_pulse(sec_pulse),
`ifdef GAME_PAUSE_EN
    .pause(pause),
`endif
    .timer_enable(timer_enable), .spawn_enable(spawn_enable), .phase(phase),
    .countdown(countdown), .level(level), .level_up(level_up), .score(score),
    .game_over(game_over)
  );

  game_phase_controller #(.SCORE_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .collision(collision), .sec_pulse(sec_pulse),
`ifdef GAME_PAUSE_EN
    .pause(pause),
`endif
    .timer_enable(timer_enable2), .spawn_enable(spawn_enable2), .phase(phase2),
    .countdown(countdown2), .level(level2), .level_up(level_up2), .score(score2),
    .game_over(game_over2)
  );

  typedef struct {
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    step = 0;
  string names[9] = '{"phase", "timer_enable", "spawn_enable", "countdown", "level",
                      "level_up", "score", "game_over", "score_sat"};

  function automatic logic [31:0] observe(input int id);
    case (id)
      0: return 32'(phase);
      1: return 32'(timer_enable);
      2: return 32'(spawn_enable);
      3: return 32'(countdown);
      4: return 32'(level);
      5: return 32'(level_up);
      6: return 32'(score);
      7: return 32'(game_over);
      8: return 32'(score2);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input int id, input int v);
    exp_t e;
    e.id  = id;
    e.val = 32'(v);
    sb.push_back(e);
  endtask

  task automatic push_all(input int ph, input int te, input int se, input int cd,
                          input int lv, input int lu, input int sc, input int go);
    push(0, ph); push(1, te); push(2, se); push(3, cd);
    push(4, lv); push(5, lu); push(6, sc); push(7, go);
    push(8, (sc > 15) ? 15 : sc);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.id);
      n_checks++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL step %0d %s observed=%0d expected=%0d", step, names[e.id], obs, e.val);
      end
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic c, input logic p, input logic pa);
    rst       = r;
    start     = s;
    collision = c;
    sec_pulse = p;
    pause     = pa;
    @(posedge clk);
    #1;
    step++;
    drain();
  endtask

  function automatic int exp_level(input int k);
    return (k / 10 > 7) ? 7 : k / 10;
  endfunction

  initial begin
    // reset held for two cycles
    push_all(0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    push_all(0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      push(0, 0); push(1, 0);
      tick(1, 0, 0, 0, 0);
    end
    push_all(0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);

    // start, then countdown ignoring start/collision
    push_all(1, 1, 0, 3, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    push_all(1, 1, 0, 3, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    push_all(1, 1, 0, 2, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    push_all(1, 1, 0, 2, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    push_all(1, 1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    push_all(2, 1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);

    // level progression and saturation at MAX_LEVEL; start ignored in PLAY
    for (int k = 1; k <= 90; k++) begin
      push_all(2, 1, 1, 0, exp_level(k), (k % 10 == 0 && k <= 70) ? 1 : 0, k, 0);
      tick(1, 0, 0, 1, 0);
      push_all(2, 1, 1, 0, exp_level(k), 0, k, 0);
      tick(1, (k == 45), 0, 0, 0);
    end

    // collision ends the game; sec_pulse in OVER has no effect
    push_all(3, 0, 0, 0, 7, 0, 90, 1);
    tick(1, 0, 1, 0, 0);
    push_all(3, 0, 0, 0, 7, 0, 90, 1);
    tick(1, 0, 0, 1, 0);

    // restart, start held high for a second cycle
    push_all(1, 1, 0, 3, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    push_all(1, 1, 0, 3, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    push_all(1, 1, 0, 2, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    push_all(1, 1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    push_all(2, 1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      push_all(2, 1, 1, 0, 0, 0, k, 0);
      tick(1, 0, 0, 1, 0);
    end

    // collision and sec_pulse together: collision wins, score stays 5
    push_all(3, 0, 0, 0, 0, 0, 5, 1);
    tick(1, 0, 1, 1, 0);

    push_all(1, 1, 0, 3, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    push_all(1, 1, 0, 2, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    push_all(1, 1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    push_all(2, 1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);

    // level-second counter must have been cleared: first level_up on the 10th second
    for (int k = 1; k <= 10; k++) begin
      push_all(2, 1, 1, 0, (k == 10) ? 1 : 0, (k == 10) ? 1 : 0, k, 0);
      tick(1, 0, 0, 1, 0);
    end

`ifdef GAME_PAUSE_EN
    push_all(2, 0, 0, 0, 1, 0, 10, 0);
    tick(1, 0, 0, 0, 1);
    push_all(2, 0, 0, 0, 1, 0, 10, 0);
    tick(1, 0, 1, 1, 1);
    push_all(2, 1, 1, 0, 1, 0, 10, 0);
    tick(1, 0, 0, 0, 0);
    push_all(2, 1, 1, 0, 1, 0, 11, 0);
    tick(1, 0, 0, 1, 0);
`endif

    // reset mid-play aborts the game
    push_all(0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    push_all(0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
